// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for fifo_ctrl.
// The FIFO side takes the slave modport, the producer/consumer side takes master.
interface fifo_if #(
    parameter int Data_width = 8,
    parameter int Addr_width = 10
);
    logic                  wr_en;
    logic [Data_width-1:0] wr_data;
    logic                  full;
    logic                  rd_en;
    logic [Data_width-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic [Addr_width:0]   count;
    logic                  ovf;
    logic                  udf;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, rd_data, rd_valid, empty, count, ovf, udf
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, rd_data, rd_valid, empty, count, ovf, udf
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller around an external registered-read dual-port RAM.
// Define FIFO_FWFT_EN to build first-word fall-through mode with a 2-entry prefetch buffer.
module fifo_ctrl #(
    parameter int Data_width = 8,
    parameter int Addr_width = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_if.slave                 bus,
    output logic                  ram_we,
    output logic [Addr_width-1:0] ram_w_addr,
    output logic [Addr_width-1:0] ram_r_addr,
    output logic [Data_width-1:0] ram_d,
    input  logic [Data_width-1:0] ram_q
);

    localparam int DEPTH = 1 << Addr_width;
    localparam logic [Addr_width:0] DEPTH_CNT = (Addr_width+1)'(DEPTH);

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  pop;
    logic                  udf_next;
    logic [Addr_width-1:0] wr_ptr_reg;
    logic [Addr_width-1:0] rd_ptr_reg;
    logic [Addr_width:0]   count_reg;
    logic [Addr_width:0]   count_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  ovf_reg;
    logic                  udf_reg;

    assign wr_acc     = bus.wr_en & ~full_reg;
    assign ram_we     = wr_acc;
    assign ram_w_addr = wr_ptr_reg;
    assign ram_d      = bus.wr_data;
    assign ram_r_addr = rd_ptr_reg;

    assign bus.full  = full_reg;
    assign bus.empty = empty_reg;
    assign bus.count = count_reg;
    assign bus.ovf   = ovf_reg;
    assign bus.udf   = udf_reg;

    // count tracks every word held, including any sitting in the output buffer
    always_comb begin
        count_next = count_reg;
        case ({wr_acc, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_CNT);
            empty_reg <= (count_next == '0);
            ovf_reg   <= bus.wr_en & full_reg;
            udf_reg   <= udf_next;
        end
    end

`ifdef FIFO_FWFT_EN
    logic [1:0]            buf_cnt_reg;
    logic                  inflight_reg;
    logic [Data_width-1:0] buf_reg [2];
    logic [Addr_width:0]   ram_cnt_reg;
    logic [2:0]            occ;

    assign pop      = bus.rd_en & (buf_cnt_reg != 2'd0);
    assign occ      = {1'b0, buf_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    // prefetch only while the buffer can still absorb the word returning next cycle
    assign rd_acc   = (ram_cnt_reg != '0) && (occ < 3'd2);
    assign udf_next = bus.rd_en & (buf_cnt_reg == 2'd0);

    assign bus.rd_valid = (buf_cnt_reg != 2'd0);
    assign bus.rd_data  = (buf_cnt_reg != 2'd0) ? buf_reg[0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt_reg  <= 2'd0;
            inflight_reg <= 1'b0;
            ram_cnt_reg  <= '0;
            for (int i = 0; i < 2; i++) buf_reg[i] <= '0;
        end else begin
            inflight_reg <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   ram_cnt_reg <= ram_cnt_reg + 1'b1;
                2'b01:   ram_cnt_reg <= ram_cnt_reg - 1'b1;
                default: ram_cnt_reg <= ram_cnt_reg;
            endcase
            case ({inflight_reg, pop})
                2'b01: begin
                    buf_reg[0]  <= buf_reg[1];
                    buf_cnt_reg <= buf_cnt_reg - 2'd1;
                end
                2'b10: begin
                    buf_reg[buf_cnt_reg[0]] <= ram_q;
                    buf_cnt_reg             <= buf_cnt_reg + 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_reg == 2'd1) begin
                        buf_reg[0] <= ram_q;
                    end else begin
                        buf_reg[0] <= buf_reg[1];
                        buf_reg[1] <= ram_q;
                    end
                end
                default: buf_cnt_reg <= buf_cnt_reg;
            endcase
        end
    end
`else
    logic rd_valid_reg;

    assign pop      = bus.rd_en & ~empty_reg;
    assign rd_acc   = pop;
    assign udf_next = bus.rd_en & empty_reg;

    // RAM read data is only meaningful the cycle after an accepted read
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_data  = rd_valid_reg ? ram_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_valid_reg <= 1'b0;
        else        rd_valid_reg <= rd_acc;
    end
`endif

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that wraps the team's registered-read dual-port RAM and turns it into a single-clock FIFO.
- Owns the write/read pointers, occupancy count and full/empty flags. Drives the RAM's write enable, write address, write data and read address, and consumes its 1-cycle-latency read data.
- Sits between a producer (wr_en/wr_data) and a consumer (rd_en/rd_data); the RAM itself is instantiated alongside it, not inside it.

Parameters:
- Data_width, 8, bits per word; must match the RAM.
- Addr_width, 10, RAM address bits; FIFO depth DEPTH = 2**Addr_width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  producer write request.
- wr_data  in  Data_width  producer write word.
- full  out  1  no space; writes are ignored.
- rd_en  in  1  consumer read request (pop).
- rd_data  out  Data_width  read word.
- rd_valid  out  1  rd_data holds a valid word.
- empty  out  1  no words stored.
- count  out  Addr_width+1  words currently held, 0..DEPTH.
- ovf  out  1  one-cycle pulse: write attempted while full.
- udf  out  1  one-cycle pulse: read attempted while empty.
- ram_we  out  1  to RAM write enable.
- ram_w_addr  out  Addr_width  to RAM write address.
- ram_r_addr  out  Addr_width  to RAM read address.
- ram_d  out  Data_width  to RAM write data.
- ram_q  in  Data_width  from RAM registered read data.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, full=0, empty=1, rd_valid=0, rd_data=0, ovf=0, udf=0. RAM contents are not cleared. Reset mid-operation logically discards all stored words.
- Write accept: wr_acc = wr_en & ~full.
  - ram_we=wr_acc, ram_w_addr=wr_ptr, ram_d=wr_data (all combinational).
  - wr_ptr increments mod DEPTH on accept.
- Read accept (standard mode): rd_acc = rd_en & ~empty.
  - ram_r_addr=rd_ptr (combinational); rd_ptr increments mod DEPTH on accept.
- Read latency: the RAM registers ram[rd_ptr] on the accepting edge. rd_valid=1 for exactly the following cycle, with rd_data=ram_q in that cycle (rd_data is a combinational pass-through of ram_q). rd_valid=0 otherwise.
- Flags:
  - count updates by +wr_acc -rd_acc each cycle.
  - full=(count==DEPTH), empty=(count==0), both registered alongside count.
- Simultaneous events:
  - Flags are sampled at the start of the cycle.
  - Full with wr_en & rd_en: read accepted, write rejected (ovf=1), count goes to DEPTH-1.
  - Empty with wr_en & rd_en: write accepted, read rejected (udf=1), count goes to 1.
  - Otherwise, simultaneous accept leaves count unchanged.
- Read-during-write collision: cannot occur on the same address, because reads require count>0 and writes require count<DEPTH.
- Pointer wrap: DEPTH-1 -> 0; no other special case.
- ovf=wr_en&full and udf=rd_en&empty, registered; each is a 1-cycle pulse per offending cycle.

Optional Feature:
- Macro: FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - A 2-entry output buffer prefetches from the RAM. The head word appears on rd_data with rd_valid=1 and no rd_en.
  - rd_en acts as an acknowledge: a pop occurs when rd_en & rd_valid.
  - A prefetch read is issued when the RAM holds words and (buffered + in-flight - pop) < 2.
  - Sustained throughput is 1 word/cycle.
  - First write into an empty FIFO gives rd_valid=1 three cycles later.
  - count, empty and full count buffered words as stored.
  - udf=rd_en&~rd_valid.
- Undefined: standard mode exactly as described above; the output buffer logic is not built.

Test Plan:
- Addr_width=2: reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4, full=1 after the 4th, ram_w_addr 0,1,2,3.
- Continuing from full: wr_en with 0x55 -> ovf pulse, count stays 4; then 4 rd_en cycles -> rd_valid on each next cycle with rd_data 0x11,0x22,0x33,0x44, empty=1 at end.
- Wrap: 6 writes interleaved with 6 reads -> pointers wrap 3->0, data order preserved, no flag glitches.
- Full with wr_en&rd_en together -> read 0x11 returned, write dropped, ovf=1, count=3.
- Empty with wr_en=0xAA & rd_en together -> udf=1, count=1; rd_en next cycle -> rd_data=0xAA.
- Assert rst_n=0 mid-stream with count=3 -> outputs return to reset values immediately (async); after release, empty=1 and a read gives udf.
